p2s_shift64: RTL

Parallel-to-serial display shifter. Each transfer captures one 64-bit word, normally the output of the 64-bit 2:1 display-data selector, and shifts it MSB-first into the board's external serial-in/parallel-out display register chain. When all bits are shifted it pulses a latch strobe, then reports completion. It is the stage directly downstream of the display-data selector and drives the display connector pins.

---
 rtl/p2s_shift64.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/p2s_shift64.sv
// p2s_shift64 -- parallel-to-serial display shifter.
//
// Captures a DATA_WIDTH-bit word on an accepted start request and shifts it
// MSB-first into an external SIPO display register chain. Each bit gets
// CLK_DIV cycles of s_clk low followed by CLK_DIV cycles of s_clk high, with
// s_dat held for the whole bit period. After the last bit, s_lat pulses high
// for CLK_DIV cycles, then done pulses for one cycle.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   transfer request, sampled only while idle
//   p_data  in   parallel word, captured on the accepting edge
//   s_clk   out  serial shift clock (chain samples on its rising edge)
//   s_dat   out  serial data, MSB first
//   s_lat   out  latch strobe to the external output register
//   busy    out  high from the accepting edge until done
//   done    out  one-cycle completion pulse
// All outputs are registered.

module p2s_shift64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  s_clk,
  output logic                  s_dat,
  output logic                  s_lat,
  output logic                  busy,
  output logic                  done
);

  // Phase counter spans one full bit period (2*CLK_DIV cycles).
  localparam int unsigned PhW  = $clog2(2 * CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  localparam logic [PhW-1:0]  PhHalf  = PhW'(CLK_DIV);
  localparam logic [PhW-1:0]  PhLast  = PhW'(2 * CLK_DIV - 1);
  localparam logic [PhW-1:0]  LatLast = PhW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch,
    StDone
  } state_e;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_sreg;
  logic [BitW-1:0]       r_bit_cnt;
  logic [PhW-1:0]        r_phase;
  logic                  r_s_clk;
  logic                  r_s_dat;
  logic                  r_s_lat;
  logic                  r_busy;
  logic                  r_done;

  logic [PhW-1:0]        w_phase_nxt;

  assign w_phase_nxt = r_phase + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_phase   <= '0;
      r_s_clk   <= 1'b0;
      r_s_dat   <= 1'b0;
      r_s_lat   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_s_clk <= 1'b0;
          r_s_lat <= 1'b0;
          r_done  <= 1'b0;
          // s_dat keeps the last bit sent while idle.
          if (start) begin
            r_sreg    <= p_data;
            r_bit_cnt <= BitLast;
            r_phase   <= '0;
            r_s_dat   <= p_data[DATA_WIDTH-1];
            r_busy    <= 1'b1;
            r_state   <= StShift;
          end
        end

        StShift: begin
          if (r_phase == PhLast) begin
            r_phase <= '0;
            r_s_clk <= 1'b0;
            if (r_bit_cnt == '0) begin
              r_s_lat <= 1'b1;
              r_state <= StLatch;
            end else begin
              r_sreg    <= {r_sreg[DATA_WIDTH-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 1'b1;
              // Present the next bit together with the falling s_clk.
              r_s_dat   <= r_sreg[DATA_WIDTH-2];
            end
          end else begin
            r_phase <= w_phase_nxt;
            // s_clk is registered, so derive it from the upcoming phase.
            r_s_clk <= (w_phase_nxt >= PhHalf);
          end
        end

        StLatch: begin
          if (r_phase == LatLast) begin
            r_phase <= '0;
            r_s_lat <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_phase <= w_phase_nxt;
          end
        end

        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign s_clk = r_s_clk;
  assign s_dat = r_s_dat;
  assign s_lat = r_s_lat;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
